// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider for DIV/DIVU.
// One quotient bit is produced per clock in CALC; sign handling is done on
// magnitudes before the loop and corrected in FIXUP. A one-cycle setup phase
// in IDLE turns the latched operands into magnitudes before iteration starts.
module seq_divider #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  signed_op,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DATA_WIDTH-1:0] lo,
    output logic [DATA_WIDTH-1:0] hi
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic             r_pend;     // operands latched, magnitudes not yet loaded
    logic             r_signed;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_rem;
    logic [W-1:0]     r_quo;
    logic [W-1:0]     r_dvs;
    logic [CNT_W-1:0] r_count;
    logic [W-1:0]     r_lo;
    logic [W-1:0]     r_hi;
    logic             r_dz;

    logic [W-1:0]     w_abs_a;
    logic [W-1:0]     w_abs_b;
    logic             w_b_zero;
    logic             w_neg_q;
    logic             w_neg_r;
    logic [W:0]       w_shift;
    logic [W:0]       w_trial;
    logic             w_keep;

    // Magnitudes of the latched operands; -MIN wraps to MIN, which is the
    // correct unsigned magnitude for the most-negative value.
    assign w_abs_a  = (r_signed && r_a[W-1]) ? -r_a : r_a;
    assign w_abs_b  = (r_signed && r_b[W-1]) ? -r_b : r_b;
    assign w_b_zero = (r_b == '0);

    // Quotient is negative when operand signs differ; remainder follows the dividend.
    assign w_neg_q  = r_signed & (r_a[W-1] ^ r_b[W-1]);
    assign w_neg_r  = r_signed & r_a[W-1];

    // Restoring step: shift the next dividend bit into the partial remainder
    // and trial-subtract the divisor magnitude one bit wider than the data.
    assign w_shift  = {r_rem, r_quo[W-1]};
    assign w_trial  = w_shift - {1'b0, r_dvs};
    assign w_keep   = ~w_trial[W];

    // State register; clear wins over every state.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: the default assignment first keeps this block free of latches
        // for every path through the case statement.
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_pend) begin
                    w_next_state = w_b_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_count == CNT_W'(W - 1)) begin
                    w_next_state = S_FIXUP;
                end
            end
            S_FIXUP: w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, sign fixup and result registers.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_pend   <= 1'b0;
            r_signed <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_count  <= '0;
            r_lo     <= '0;
            r_hi     <= '0;
            r_dz     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_pend) begin
                        r_pend <= 1'b0;
                        if (w_b_zero) begin
                            r_lo <= '1;
                            r_hi <= r_a;
                            r_dz <= 1'b1;
                        end else begin
                            r_rem   <= '0;
                            r_quo   <= w_abs_a;
                            r_dvs   <= w_abs_b;
                            r_count <= '0;
                        end
                    end else if (start) begin
                        r_pend   <= 1'b1;
                        r_signed <= signed_op;
                        r_a      <= dividend;
                        r_b      <= divisor;
                    end
                end
                S_CALC: begin
                    r_rem   <= w_keep ? w_trial[W-1:0] : w_shift[W-1:0];
                    r_quo   <= {r_quo[W-2:0], w_keep};
                    r_count <= r_count + 1'b1;
                end
                S_FIXUP: begin
                    r_lo <= w_neg_q ? -r_quo : r_quo;
                    r_hi <= w_neg_r ? -r_rem : r_rem;
                    r_dz <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy        = (r_state == S_CALC) || (r_state == S_FIXUP);
    assign done        = (r_state == S_DONE);
    assign div_by_zero = r_dz;
    assign lo          = r_lo;
    assign hi          = r_hi;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random checks of seq_divider against a
// behavioural model, using a scoreboard queue of expected results.
module tb_seq_divider;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dz;
    } exp_t;

    logic         clock = 1'b0;
    logic         clear = 1'b1;
    logic         start = 1'b0;
    logic         signed_op = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] lo;
    logic [W-1:0] hi;

    int           n_checks = 0;
    int           n_errors = 0;
    exp_t         sb[$];
    logic [W-1:0] prev_lo = '0;
    logic [W-1:0] prev_hi = '0;

    seq_divider #(.DATA_WIDTH(W)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .lo          (lo),
        .hi          (hi)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.dz = 1'b0;
        if (b == '0) begin
            e.lo = '1;
            e.hi = a;
            e.dz = 1'b1;
        end else if (s) begin
            if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
                e.lo = a;
                e.hi = '0;
            end else begin
                e.lo = $signed(a) / $signed(b);
                e.hi = $signed(a) % $signed(b);
            end
        end else begin
            e.lo = a / b;
            e.hi = a % b;
        end
        return e;
    endfunction

    // Waits a number of cycles and checks that no done pulse appears.
    task automatic expect_quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (done) seen++;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    // Issues one division, optionally re-pulses start at a given edge count,
    // then checks latency, busy length and the scoreboard result.
    task automatic run_div(input string tag, input logic s, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int repulse_at);
        exp_t e;
        exp_t got;
        int   edges;
        int   busy_cnt;
        logic seen;
        logic busy_at_done;
        sb.push_back(model(s, a, b));
        @(negedge clock);
        start     = 1'b1;
        signed_op = s;
        dividend  = a;
        divisor   = b;
        @(posedge clock);
        #1;
        start     = 1'b0;
        signed_op = ~s;
        dividend  = $urandom;
        divisor   = $urandom;
        edges = 0;
        busy_cnt = 0;
        seen = 1'b0;
        busy_at_done = 1'b0;
        while (!seen && edges < 100) begin
            @(posedge clock);
            edges++;
            #1;
            start = (edges == repulse_at);
            if (start) begin
                signed_op = 1'b0;
                dividend  = 32'd5;
                divisor   = 32'd1;
            end
            @(negedge clock);
            if (done) begin
                seen = 1'b1;
                busy_at_done = busy;
            end else if (busy) begin
                busy_cnt++;
            end
            if (edges == 10) begin
                check({tag, "_lo_hold"}, 64'(lo), 64'(prev_lo));
                check({tag, "_hi_hold"}, 64'(hi), 64'(prev_hi));
            end
        end
        start = 1'b0;
        if (!seen) begin
            check({tag, "_done_timeout"}, 64'd0, 64'd1);
        end else begin
            check({tag, "_latency"}, 64'(edges), (b == '0) ? 64'd1 : 64'(W + 2));
            check({tag, "_busy_cycles"}, 64'(busy_cnt), (b == '0) ? 64'd0 : 64'(W + 1));
            check({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
            if (sb.size() == 0) begin
                check({tag, "_sb_empty"}, 64'd0, 64'd1);
            end else begin
                e = sb.pop_front();
                got = '{lo: lo, hi: hi, dz: div_by_zero};
                check({tag, "_lo"}, 64'(got.lo), 64'(e.lo));
                check({tag, "_hi"}, 64'(got.hi), 64'(e.hi));
                check({tag, "_dz"}, 64'(got.dz), 64'(e.dz));
                prev_lo = e.lo;
                prev_hi = e.hi;
            end
            @(negedge clock);
            check({tag, "_done_pulse"}, 64'(done), 64'd0);
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clock);
        #1;
        clear = 1'b0;
        @(negedge clock);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dz",   64'(div_by_zero), 64'd0);
        check("rst_lo",   64'(lo), 64'd0);
        check("rst_hi",   64'(hi), 64'd0);

        // Directed cases
        run_div("s_100_7",    1'b1, 32'd100, 32'd7, -1);
        run_div("s_m100_7",   1'b1, 32'hFFFF_FF9C, 32'd7, -1);
        run_div("s_100_m7",   1'b1, 32'd100, 32'hFFFF_FFF9, -1);
        run_div("u_ffff_2",   1'b0, 32'hFFFF_FFFF, 32'd2, -1);
        run_div("s_ffff_2",   1'b1, 32'hFFFF_FFFF, 32'd2, -1);
        run_div("div0",       1'b1, 32'h0000_1234, 32'd0, -1);
        run_div("s_ovf",      1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5);
        expect_quiet("repulse_no_extra_done", 40);
        run_div("u_div0",     1'b0, 32'hDEAD_BEEF, 32'd0, -1);
        run_div("u_1_max",    1'b0, 32'd1, 32'hFFFF_FFFF, -1);

        // Clear during CALC aborts the operation
        @(negedge clock);
        start     = 1'b1;
        signed_op = 1'b1;
        dividend  = 32'd1000;
        divisor   = 32'd3;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        clear = 1'b1;
        @(posedge clock);
        #1;
        clear = 1'b0;
        @(negedge clock);
        check("clr_busy", 64'(busy), 64'd0);
        check("clr_done", 64'(done), 64'd0);
        check("clr_lo",   64'(lo), 64'd0);
        check("clr_hi",   64'(hi), 64'd0);
        prev_lo = '0;
        prev_hi = '0;
        expect_quiet("clr_no_done", 40);
        run_div("post_clr", 1'b1, 32'hFFFF_FC18, 32'd3, -1);

        // Random regression for both signedness modes
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = $urandom;
            case (i % 4)
                0: b = $urandom;
                1: b = $urandom_range(15, 1);
                2: b = -($urandom_range(15, 1));
                default: b = $urandom >> $urandom_range(31, 0);
            endcase
            if (i == 13) b = '0;
            run_div($sformatf("rnd%0d", i), i[0], a, b, -1);
        end

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
